uart_sin_conditioner: RTL and testbench



---
 rtl/uart_sin_cond_pkg.sv | 25 ++
 rtl/uart_sin_glitch_filter.sv | 48 ++++
 rtl/uart_sin_conditioner.sv | 167 ++++++++++++++++
 tb/tb_uart_sin_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_sin_cond_pkg.sv
// UART serial-input conditioner: shared register map, bit positions
// and line-state encoding.
package uart_sin_cond_pkg;

    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_BREAK_LEN = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_IDLE_LEN  = 2'd3;

    localparam int CTRL_EN      = 4;
    localparam int CTRL_BRK_IE  = 5;
    localparam int CTRL_IDLE_IE = 6;

    localparam int ST_BRK_ACT   = 0;
    localparam int ST_BRK_SEEN  = 1;
    localparam int ST_IDLE_SEEN = 2;
    localparam int ST_GLITCH    = 3;

    typedef enum logic [1:0] {
        LINE_IDLE,
        LINE_ACTIVE,
        LINE_BREAK
    } line_state_t;

endpackage

// File: rtl/uart_sin_glitch_filter.sv
// Pad synchroniser plus run-length glitch filter; filt_out follows the
// pad only after it has held a new level for max(filt_len,1) cycles.
module uart_sin_glitch_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad,
    input  logic [3:0] filt_len,
    output logic       filt_out,
    output logic       glitch_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q;
    logic                   sync_out;
    logic                   differ;
    logic [4:0]             cnt_inc;
    logic [4:0]             eff_len;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign differ       = sync_out != filt_out;
    assign cnt_inc      = {1'b0, cnt_q} + 5'd1;
    assign eff_len      = (filt_len == 4'd0) ? 5'd1 : {1'b0, filt_len};
    assign glitch_pulse = !differ && (cnt_q != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '1;
            filt_out <= 1'b1;
            cnt_q    <= 4'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            if (differ) begin
                // >= so a lowered filt_len takes effect with cnt above it
                if (cnt_inc >= eff_len) begin
                    filt_out <= sync_out;
                    cnt_q    <= 4'd0;
                end else begin
                    cnt_q <= cnt_inc[3:0];
                end
            end else begin
                cnt_q <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/uart_sin_conditioner.sv
// Conditions the UART0 SIN pad: sync + glitch filter, break/idle
// detection with interrupt, and a 4-word Wishbone register window.
module uart_sin_conditioner #(
    parameter int                   SYNC_STAGES   = 2,
    parameter int                   CNT_WIDTH     = 20,
    parameter logic [3:0]           DEF_FILT_LEN  = 4'd3,
    parameter logic [CNT_WIDTH-1:0] DEF_BREAK_LEN = CNT_WIDTH'(2000),
    parameter logic [CNT_WIDTH-1:0] DEF_IDLE_LEN  = CNT_WIDTH'(200)
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic [1:0]  WBs_ADR_i,
    input  logic        WBs_CYC_i,
    input  logic [3:0]  WBs_BYTE_STB_i,
    input  logic        WBs_WE_i,
    input  logic        WBs_STB_i,
    input  logic [31:0] WBs_DAT_i,
    output logic [31:0] WBs_DAT_o,
    output logic        WBs_ACK_o,
    input  logic        SIN_pad_i,
    output logic        SIN_o,
    output logic        BREAK_o,
    output logic        Intr_o
);

    import uart_sin_cond_pkg::*;

    logic [3:0]           filt_len;
    logic                 enable, break_ie, idle_ie;
    logic [CNT_WIDTH-1:0] break_len, idle_len, run_cnt, run_n;
    logic                 break_seen, idle_seen, glitch_seen;
    logic [7:0]           glitch_cnt;
    logic                 filt_out, filt_q, glitch_pulse;
    logic                 chg, fall, rise;
    logic                 set_break, set_idle;
    line_state_t          state_q, state_n, mid;
    logic                 wb_req, wb_commit, wr_status;
    logic                 clr_brk, clr_idle, clr_glitch;
    logic [31:0]          rdata;
    logic                 unused_bits;

    uart_sin_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filt (
        .clk          (WBs_CLK_i),
        .rst          (WBs_RST_i),
        .pad          (SIN_pad_i),
        .filt_len     (filt_len),
        .filt_out     (filt_out),
        .glitch_pulse (glitch_pulse)
    );

    assign SIN_o       = enable ? filt_out : 1'b1;
    assign chg         = filt_out ^ filt_q;
    assign fall        = chg & ~filt_out;
    assign rise        = chg & filt_out;
    assign unused_bits = ^{WBs_DAT_i, WBs_BYTE_STB_i};

    assign wb_req     = WBs_CYC_i & WBs_STB_i;
    assign wb_commit  = wb_req & WBs_WE_i & WBs_ACK_o;
    assign wr_status  = wb_commit && (WBs_ADR_i == REG_STATUS)
                        && WBs_BYTE_STB_i[0];
    assign clr_brk    = wr_status & WBs_DAT_i[ST_BRK_SEEN];
    assign clr_idle   = wr_status & WBs_DAT_i[ST_IDLE_SEEN];
    assign clr_glitch = wr_status & WBs_DAT_i[ST_GLITCH];

    // The edge is seen one cycle late, so the run restarts at 1 and
    // run_n equals the cycles filt_out has held its current level.
    always_comb begin
        run_n     = '0;
        state_n   = state_q;
        mid       = state_q;
        set_break = 1'b0;
        set_idle  = 1'b0;
        if (enable) begin
            if (chg)
                run_n = CNT_WIDTH'(1);
            else if (&run_cnt)
                run_n = run_cnt;
            else
                run_n = run_cnt + CNT_WIDTH'(1);
            if (fall && state_q == LINE_IDLE)
                mid = LINE_ACTIVE;
            if (rise && state_q == LINE_BREAK)
                mid = LINE_ACTIVE;
            state_n = mid;
            if (mid == LINE_ACTIVE) begin
                if (!filt_out && break_len != '0 && run_n == break_len) begin
                    state_n   = LINE_BREAK;
                    set_break = 1'b1;
                end else if (filt_out && idle_len != '0
                             && run_n == idle_len) begin
                    state_n  = LINE_IDLE;
                    set_idle = 1'b1;
                end
            end
        end else begin
            state_n = LINE_IDLE;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (WBs_ADR_i)
            REG_CTRL:      rdata = {25'd0, idle_ie, break_ie, enable, filt_len};
            REG_BREAK_LEN: rdata = 32'(break_len);
            REG_STATUS:    rdata = {16'd0, glitch_cnt, 4'd0, glitch_seen,
                                    idle_seen, break_seen, BREAK_o};
            REG_IDLE_LEN:  rdata = 32'(idle_len);
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            filt_len    <= DEF_FILT_LEN;
            enable      <= 1'b1;
            break_ie    <= 1'b0;
            idle_ie     <= 1'b0;
            break_len   <= DEF_BREAK_LEN;
            idle_len    <= DEF_IDLE_LEN;
            break_seen  <= 1'b0;
            idle_seen   <= 1'b0;
            glitch_seen <= 1'b0;
            glitch_cnt  <= 8'd0;
            filt_q      <= 1'b1;
            run_cnt     <= '0;
            state_q     <= LINE_IDLE;
            BREAK_o     <= 1'b0;
            Intr_o      <= 1'b0;
            WBs_ACK_o   <= 1'b0;
            WBs_DAT_o   <= '0;
        end else begin
            WBs_ACK_o <= wb_req & ~WBs_ACK_o;
            WBs_DAT_o <= (wb_req & ~WBs_ACK_o) ? rdata : '0;
            filt_q    <= filt_out;
            run_cnt   <= run_n;
            state_q   <= state_n;
            BREAK_o   <= (state_n == LINE_BREAK);
            Intr_o    <= (break_seen & break_ie) | (idle_seen & idle_ie);

            if (wb_commit && WBs_ADR_i == REG_CTRL && WBs_BYTE_STB_i[0]) begin
                filt_len <= WBs_DAT_i[3:0];
                enable   <= WBs_DAT_i[CTRL_EN];
                break_ie <= WBs_DAT_i[CTRL_BRK_IE];
                idle_ie  <= WBs_DAT_i[CTRL_IDLE_IE];
            end
            for (int i = 0; i < CNT_WIDTH; i++) begin
                if (wb_commit && WBs_BYTE_STB_i[i/8]) begin
                    if (WBs_ADR_i == REG_BREAK_LEN)
                        break_len[i] <= WBs_DAT_i[i];
                    if (WBs_ADR_i == REG_IDLE_LEN)
                        idle_len[i] <= WBs_DAT_i[i];
                end
            end

            // hardware set beats a simultaneous W1C
            break_seen  <= set_break | (break_seen & ~clr_brk);
            idle_seen   <= set_idle | (idle_seen & ~clr_idle);
            glitch_seen <= glitch_pulse | (glitch_seen & ~clr_glitch);
            if (clr_glitch)
                glitch_cnt <= glitch_pulse ? 8'd1 : 8'd0;
            else if (glitch_pulse && glitch_cnt != 8'hFF)
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_sin_conditioner.sv
// Directed bench for uart_sin_conditioner: filter timing, break/idle
// detection, interrupts, W1C behaviour and glitch counter saturation.
module tb_uart_sin_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr;
    logic        cyc, we, stb;
    logic [3:0]  be;
    logic [31:0] dat_i, dat_o;
    logic        ack, pad, sin, brk, irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_sin_conditioner dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc),
        .WBs_BYTE_STB_i (be),
        .WBs_WE_i       (we),
        .WBs_STB_i      (stb),
        .WBs_DAT_i      (dat_i),
        .WBs_DAT_o      (dat_o),
        .WBs_ACK_o      (ack),
        .SIN_pad_i      (pad),
        .SIN_o          (sin),
        .BREAK_o        (brk),
        .Intr_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a,
                           input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; be = 4'hF;
        @(negedge clk);
        check("wb_ack_hi", {31'd0, ack}, 32'd1);
        rd = dat_o;
        @(negedge clk);
        check("wb_ack_lo", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(1'b1, a, d, rd);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, rd);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  v10;
        logic [15:0] sv, iv;
        logic [5:0]  v6;
        logic        all_one, brk_any;
        int          first_sin, first_brk;

        rst = 1'b1; pad = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 2'd0; be = 4'h0; dat_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_sin", {31'd0, sin}, 32'd1);
        check("rst_brk", {31'd0, brk}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_sin", {31'd0, sin}, 32'd1);
        wb_read(2'd0, rd); check("ctrl_rst", rd, 32'h13);
        wb_read(2'd1, rd); check("brklen_rst", rd, 32'd2000);
        wb_read(2'd3, rd); check("idlelen_rst", rd, 32'd200);
        wb_read(2'd2, rd); check("status_rst", rd, 32'd0);
        pad = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 2-cycle low pulse is filtered out with L=3
        @(negedge clk); pad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); v10[k-1] = sin;
            if (k == 2) pad = 1'b1;
        end
        check("glitch_sin", {22'd0, v10}, 32'h3FF);
        wb_read(2'd2, rd); check("glitch_status", rd, 32'h0108);

        // 4-cycle low pulse passes after SYNC+L = 5 cycles
        @(negedge clk); pad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); v10[k-1] = sin;
            if (k == 4) pad = 1'b1;
        end
        check("pass4_sin", {22'd0, v10}, 32'h30F);

        // break detection
        wb_write(2'd3, 32'd0);
        wb_write(2'd1, 32'd10);
        wb_write(2'd0, 32'h33);
        wb_write(2'd2, 32'hE);
        check("brk_irq_pre", {31'd0, irq}, 32'd0);
        @(negedge clk); pad = 1'b0;
        first_sin = 0; first_brk = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!sin && first_sin == 0) first_sin = k;
            if (brk && first_brk == 0) first_brk = k;
        end
        check("brk_sin_fall", first_sin, 5);
        check("brk_rise", first_brk, 15);
        check("brk_irq", {31'd0, irq}, 32'd1);
        pad = 1'b1;
        wb_read(2'd2, rd); check("brk_status", rd, 32'h3);
        repeat (10) @(negedge clk);
        check("brk_clear", {31'd0, brk}, 32'd0);
        wb_write(2'd2, 32'h2);
        @(negedge clk);
        check("brk_irq_w1c", {31'd0, irq}, 32'd0);

        // idle detection
        wb_write(2'd0, 32'h53);
        wb_write(2'd3, 32'd5);
        @(negedge clk); pad = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); sv[k-1] = sin; iv[k-1] = irq;
            if (k == 3) pad = 1'b1;
        end
        check("idle_sin", {16'd0, sv}, 32'hFF8F);
        check("idle_irq", {16'd0, iv}, 32'hE000);
        repeat (20) @(negedge clk);
        check("idle_irq_level", {31'd0, irq}, 32'd1);
        wb_write(2'd2, 32'h4);
        repeat (30) @(negedge clk);
        check("idle_once_irq", {31'd0, irq}, 32'd0);
        wb_read(2'd2, rd); check("idle_once", rd, 32'd0);

        // L=0 and L=1 both pass a 1-cycle pulse after 3 cycles
        for (int l = 0; l <= 1; l++) begin
            wb_write(2'd0, 32'h10 | l);
            @(negedge clk); pad = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk); v6[k-1] = sin;
                if (k == 1) pad = 1'b1;
            end
            check(l == 0 ? "l0_sin" : "l1_sin", {26'd0, v6}, 32'h3B);
            repeat (10) @(negedge clk);
        end

        // disabled: SIN_o held high, no detection
        wb_write(2'd0, 32'h63);
        wb_write(2'd2, 32'hE);
        all_one = 1'b1; brk_any = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            all_one &= sin; brk_any |= brk;
            if (k % 20 == 0) pad = ~pad;
        end
        check("dis_sin", {31'd0, all_one}, 32'd1);
        check("dis_brk", {31'd0, brk_any}, 32'd0);
        wb_read(2'd2, rd); check("dis_status", rd, 32'd0);
        check("dis_irq", {31'd0, irq}, 32'd0);
        repeat (10) @(negedge clk);

        // glitch flag: plain clear, then clear coinciding with a glitch
        wb_write(2'd0, 32'h13);
        @(negedge clk); pad = 1'b0;
        @(negedge clk);
        @(negedge clk); pad = 1'b1;
        repeat (6) @(negedge clk);
        wb_read(2'd2, rd); check("glitch_one", rd, 32'h0108);
        wb_write(2'd2, 32'h8);
        wb_read(2'd2, rd); check("glitch_clr", rd, 32'd0);
        @(negedge clk); pad = 1'b0;
        @(negedge clk);
        @(negedge clk); pad = 1'b1;
        wb_write(2'd2, 32'h8);
        wb_read(2'd2, rd); check("w1c_vs_hw", rd & 32'h8, 32'h8);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk); pad = 1'b0;
            @(negedge clk);
            @(negedge clk); pad = 1'b1;
            repeat (6) @(negedge clk);
        end
        wb_read(2'd2, rd);
        check("glitch_sat", (rd >> 8) & 32'hFF, 32'hFF);
        check("glitch_sat_status", rd, 32'hFF08);
        check("glitch_sin_end", {31'd0, sin}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
